// File: rtl/instruction_fetch.sv
// Fetch stage: one request/ack read per PC and holds the word until decode takes it.
// Define FETCH_STALL_CNT_EN to add the stall_cycles counter output.
module instruction_fetch #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       pc_in,
  output logic              pc_en,
  output logic              mem_req,
  output logic [31:0]       mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  input  logic              decode_ready,
  input  logic              flush,
  output logic [31:0]       instr_out,
  output logic [31:0]       instr_pc,
  output logic              instr_valid,
`ifdef FETCH_STALL_CNT_EN
  output logic [CNT_W-1:0]  stall_cycles,
`endif
  output logic              misalign_fault
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_t;
  state_t state;

  assign pc_en = (state == HOLD) && decode_ready && !flush;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      mem_req        <= 1'b0;
      mem_addr       <= '0;
      instr_out      <= NOP_INSTR;
      instr_pc       <= '0;
      instr_valid    <= 1'b0;
      misalign_fault <= 1'b0;
    end else begin
      case (state)
        IDLE: if (!flush) begin
          if (pc_in[1:0] == 2'b00) begin
            mem_addr <= pc_in;
            mem_req  <= 1'b1;
            state    <= FETCH;
          end else begin
            instr_out      <= NOP_INSTR;
            instr_pc       <= pc_in;
            misalign_fault <= 1'b1;
            instr_valid    <= 1'b1;
            state          <= HOLD;
          end
        end
        FETCH: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!flush) begin
              instr_out      <= mem_rdata;
              instr_pc       <= mem_addr;
              instr_valid    <= 1'b1;
              misalign_fault <= 1'b0;
              state          <= HOLD;
            end else begin
              state <= IDLE;
            end
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        // A request is never withdrawn before its ack; the late data is dropped.
        DRAIN: if (mem_ack) begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
        HOLD: if (flush || decode_ready) begin
          instr_valid    <= 1'b0;
          misalign_fault <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_STALL_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      stall_cycles <= '0;
    else if ((state == FETCH || state == DRAIN) && !mem_ack && !(&stall_cycles))
      stall_cycles <= stall_cycles + 1'b1;
  end
`endif

endmodule
